// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for a unified instruction/data memory port. One word
//   access (fetch, load or store) is captured per request, a fixed number of
//   wait states is inserted, and a single-cycle ready pulse is returned with the
//   registered read word. Stores write only the byte lanes selected by be.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, 16..65536)
//   LATENCY  wait-state cycles between capture and response (0..15)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high
//   req    in   request strobe, sampled only while idle
//   we     in   1 = store, 0 = read
//   addr   in   byte address; low two bits ignored, upper bits alias
//   wdata  in   store data, lane i = wdata[8i+7:8i]
//   be     in   byte-lane write enables (stores only)
//   rdata  out  read word registered on the edge that enters RESP
//   ready  out  one-cycle response pulse (RESP state)
//   busy   out  high while an access is in flight (WAIT or RESP)
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt;

  // Request registers captured in IDLE
  logic            we_p0;
  logic [AW-1:0]   idx_p0;
  logic [31:0]     wdata_p0;
  logic [3:0]      be_p0;

  logic [31:0]     mem [DEPTH];

  // Access currently being served. With zero wait states the capture edge is
  // also the response edge, so the live inputs must be used directly.
  logic            resp_go;
  logic            acc_we;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_be;

  // Only the word-index bits of the address are meaningful.
  logic            unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and access-select logic
  always_comb begin
    ready     = (state == RESP);
    busy      = (state != IDLE);
    resp_go   = (state != RESP) && (state_nxt == RESP);
    acc_we    = we_p0;
    acc_idx   = idx_p0;
    acc_wdata = wdata_p0;
    acc_be    = be_p0;
    if (state == IDLE) begin
      acc_we    = we;
      acc_idx   = addr[AW+1:2];
      acc_wdata = wdata;
      acc_be    = be;
    end
  end

  // Capture / wait counter / read data
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 4'd0;
      we_p0    <= 1'b0;
      idx_p0   <= '0;
      wdata_p0 <= 32'd0;
      be_p0    <= 4'd0;
      rdata    <= 32'd0;
    end else begin
      if (state == IDLE && req) begin
        we_p0    <= we;
        idx_p0   <= addr[AW+1:2];
        wdata_p0 <= wdata;
        be_p0    <= be;
        cnt      <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Old word is returned even for a store (read-before-write).
      if (resp_go) begin
        rdata <= mem[acc_idx];
      end
    end
  end

  // Memory array: not cleared by reset; a reset on the response edge cancels
  // the store.
  always_ff @(posedge clk) begin
    if (!reset && resp_go && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
